// File: rtl/clk_cfg_apb_bridge.sv
// clk_cfg_apb_bridge: APB slave to clock-generator config handshake plus lock/timeout status; CLK_CFG_TIMEOUT_EN enables the ack timeout
module clk_cfg_apb_bridge #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [31:0]               pwdata_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      cfg_req_o,
  input  logic                      cfg_ack_i,
  output logic [1:0]                cfg_add_o,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_wrn_o,
  input  logic [31:0]               cfg_r_data_i,
  input  logic                      cfg_lock_i
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state;
  logic acc, loc_acc, tgt_acc, to_hit, to_flag, err, lock_s1, lock_s2, unused;
  logic [31:0] cap;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end
  assign acc = rst_ni & psel_i & penable_i & (state == IDLE);
  assign loc_acc = acc & paddr_i[4];
  assign tgt_acc = acc & ~paddr_i[4];
  assign unused = ^{paddr_i, pwdata_i};
`ifdef CLK_CFG_TIMEOUT_EN
  logic [15:0] to_cnt;
  assign to_hit = (state == REQ) & ~cfg_ack_i & (to_cnt == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt <= '0;
      to_flag <= 1'b0;
    end else begin
      to_cnt <= (state == REQ) ? to_cnt + 16'd1 : 16'd0;
      to_flag <= to_hit | (to_flag & ~(loc_acc & pwrite_i & pwdata_i[1]));
    end
  end
`else
  assign to_hit = 1'b0;
  assign to_flag = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      lock_s1 <= cfg_lock_i;
      lock_s2 <= lock_s1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cfg_req_o <= 1'b0;
      cfg_add_o <= 2'd0;
      cfg_data_o <= 32'd0;
      cfg_wrn_o <= 1'b1;
      cap <= 32'd0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tgt_acc) begin
          state <= REQ;
          cfg_req_o <= 1'b1;
          cfg_add_o <= paddr_i[3:2];
          cfg_data_o <= pwdata_i;
          cfg_wrn_o <= ~pwrite_i;
        end
        REQ: if (cfg_ack_i || to_hit) begin
          state <= DONE;
          cfg_req_o <= 1'b0;
          cap <= (cfg_ack_i && cfg_wrn_o) ? cfg_r_data_i : 32'd0;
          err <= ~cfg_ack_i;
        end
        default: begin
          state <= IDLE;
          cap <= 32'd0;
          err <= 1'b0;
        end
      endcase
    end
  end
  assign pready_o = (state == DONE) | loc_acc;
  assign pslverr_o = (state == DONE) & err;
  assign prdata_o = (state == DONE) ? cap : loc_acc ? {30'd0, to_flag, lock_s2} : 32'd0;
endmodule

// File: doc/clk_cfg_apb_bridge.md
CLK_CFG_APB_BRIDGE -- requirements
Module: clk_cfg_apb_bridge

Interface
REQ-001 The block SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, ack wait limit in cycles (1..65535).
REQ-003 The block SHALL have these ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- paddr_i  in  APB_ADDR_WIDTH  APB address.
- psel_i, penable_i, pwrite_i  in  1 each  APB controls.
- pwdata_i  in  32  APB write data.
- prdata_o  out  32  APB read data.
- pready_o, pslverr_o  out  1 each  APB response.
- cfg_req_o  out  1  config request to the clock generator.
- cfg_ack_i  in  1  config acknowledge.
- cfg_add_o  out  2  config register index.
- cfg_data_o  out  32  config write data.
- cfg_wrn_o  out  1  1 = read, 0 = write.
- cfg_r_data_i  in  32  config read data.
- cfg_lock_i  in  1  clock generator lock, asynchronous.

Function
REQ-004 Address decode SHALL be: paddr_i[4]=0 is a target access with cfg_add_o=paddr_i[3:2]; paddr_i[4]=1 is the local status register; all other bits are ignored.
REQ-005 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-006 In IDLE, a local access (psel_i&penable_i, paddr_i[4]=1) SHALL complete with pready_o=1 in the same cycle.
REQ-007 In IDLE, a target access (psel_i&penable_i, paddr_i[4]=0) SHALL hold pready_o=0, register add/data/wrn (cfg_wrn_o=~pwrite_i), and move to REQ.
REQ-008 In REQ, cfg_req_o SHALL be 1, and cfg_add_o/cfg_data_o/cfg_wrn_o SHALL stay stable until the cycle in which cfg_ack_i=1 is sampled.
REQ-009 On a sampled ack, the block SHALL capture cfg_r_data_i (read only; writes capture 0) and move to DONE; cfg_req_o SHALL be 0 from the next cycle.
REQ-010 A combinational ack (high in the first REQ cycle) SHALL be accepted.
REQ-011 In DONE, pready_o SHALL be 1 for exactly one cycle, prdata_o SHALL equal the captured data, and the FSM SHALL return to IDLE.
REQ-012 Minimum target latency SHALL be: access-phase cycle T, cfg_req_o high at T+1, pready_o high at T+2.
REQ-013 prdata_o SHALL be 0 whenever pready_o=0.
REQ-014 The status register SHALL contain:
- bit0: cfg_lock_i after a 2-flop synchronizer, read-only.
- bit1: sticky timeout flag; writing 1 to bit1 clears it.
- other bits: read 0.
REQ-015 If timeout set and clear coincide in one cycle, set SHALL win.
REQ-016 APB accesses SHALL NOT be accepted in REQ or DONE; a master that keeps PSEL/PENABLE asserted SHALL be serviced in order.
REQ-017 pslverr_o SHALL be 0 except as defined in REQ-021.

Reset
REQ-018 While rst_ni=0, the block SHALL force:
- FSM to IDLE.
- cfg_req_o=0, cfg_add_o=0, cfg_data_o=0, cfg_wrn_o=1.
- pready_o=0, pslverr_o=0, prdata_o=0.
- timeout flag, timeout counter, synchronizer flops and captured data to 0.
REQ-019 Reset asserted mid-transaction SHALL drop cfg_req_o asynchronously, with no APB completion.
REQ-020 After reset release, the first access SHALL be accepted on the first clk_i edge.

Configuration
REQ-021 With CLK_CFG_TIMEOUT_EN defined, a 16-bit counter SHALL count REQ cycles. When the count reaches TIMEOUT_CYCLES without an ack, the block SHALL:
- drop cfg_req_o and go to DONE.
- complete the APB access with pslverr_o=1 and prdata_o=0.
- set status bit1.
An ack in the same cycle as the limit SHALL win, giving normal completion.
REQ-022 Without CLK_CFG_TIMEOUT_EN, REQ SHALL wait indefinitely, pslverr_o SHALL be tied to 0, status bit1 SHALL read 0, and no counter SHALL exist.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Write 0x12345678 to paddr 0x008, ack tied high -> cfg_add_o=2, cfg_wrn_o=0, cfg_data_o=0x12345678, cfg_req_o high 1 cycle, pready_o at T+2.
- Read paddr 0x004, ack delayed 5 cycles, cfg_r_data_i=0xBEEF0003 -> cfg_req_o high 6 cycles, prdata_o=0xBEEF0003 with pready_o, pslverr_o=0.
- Read paddr 0x010 with cfg_lock_i rising 1 cycle earlier -> bit0=0; same read 3 cycles later -> prdata_o=0x1.
- With macro and TIMEOUT_CYCLES=4, ack never given -> cfg_req_o drops after 4 cycles, pslverr_o=1, prdata_o=0, status reads 0x2 (lock low); write 0x2 to 0x010 -> status reads 0x0.
- rst_ni pulsed low during REQ -> cfg_req_o=0 immediately, no pready_o; next write completes normally.
